// File: rtl/cu_if_fetch_pkg.sv
// Shared types and constants for the CU instruction-fetch stage.
package cu_if_fetch_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0) presented to decode before any real fetch.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_FLUSH,
    S_FAULT
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS_ERR  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

endpackage

// File: rtl/cu_if_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface cu_if_fetch_if;
  import cu_if_fetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;
  logic            err;

  modport master (output req, output addr, input ack, input rdata, input err);
  modport slave  (input req, input addr, output ack, output rdata, output err);

endinterface

// File: rtl/cu_if_fetch_timeout_ctr.sv
// Counts cycles spent waiting on imem_ack; saturates and flags expiry at
// TIMEOUT_CYCLES-1 so a redirect arriving on the expiry cycle cannot wrap it.
module cu_if_fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  assign expire = (count_q == LAST);

  // Next count: clear wins, otherwise step while enabled and not yet expired.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/cu_if_fetch.sv
// CU instruction-fetch stage: owns the PC, fetches words over the imem bus,
// hands them to decode via Cu_IR/Fetch_ready, and handles stall, redirect
// (with in-flight discard) and fetch faults.
module cu_if_fetch
  import cu_if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            soc_clk,
  input  logic            IF_reset,
  input  logic            IF_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  cu_if_fetch_if.master   imem,
  output logic [XLEN-1:0] Cu_IR,
  output logic [XLEN-1:0] fetch_pc,
  output logic            Fetch_ready,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] flush_addr_q, flush_addr_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  fault_cause_e    cause_q, cause_d;

  logic in_flight;
  logic ctr_clear;
  logic ctr_expire;

  // During a flush the old request must stay stable even though pc already
  // holds the redirect target, hence the separate flush address.
  assign in_flight   = (state_q == S_FETCH) || (state_q == S_FLUSH);
  assign imem.req    = in_flight;
  assign imem.addr   = (state_q == S_FLUSH) ? flush_addr_q : pc_q;
  assign Cu_IR       = ir_q;
  assign fetch_pc    = fpc_q;
  assign Fetch_ready = ready_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

  // The wait counter only runs while a request stays outstanding in the same
  // state; any transition, ack or restart begins a fresh wait.
  assign ctr_clear = !(in_flight && (state_d == state_q) && !imem.ack);

  cu_if_fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (soc_clk),
    .rst   (IF_reset),
    .clear (ctr_clear),
    .enable(!ctr_clear),
    .expire(ctr_expire)
  );

  // Next-state logic: redirect outranks stall, ack and timeout.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    ir_d         = ir_q;
    fpc_d        = fpc_q;
    ready_d      = 1'b0;
    fault_d      = fault_q;
    cause_d      = cause_q;

    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      cause_d = CAUSE_MISALIGN;
    end else if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
      cause_d = CAUSE_NONE;
      case (state_q)
        S_FETCH: begin
          if (imem.ack) begin
            state_d = S_FETCH;
          end else begin
            state_d      = S_FLUSH;
            flush_addr_d = pc_q;
          end
        end
        S_FLUSH: state_d = imem.ack ? S_FETCH : S_FLUSH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_FETCH: begin
          if (imem.ack && imem.err) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_BUS_ERR;
          end else if (imem.ack) begin
            state_d = S_HOLD;
            ir_d    = imem.rdata;
            fpc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
            ready_d = 1'b1;
          end else if (ctr_expire) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_HOLD: begin
          if (!IF_stall) state_d = S_FETCH;
        end
        S_FLUSH: begin
          if (imem.ack) begin
            state_d = S_FETCH;
          end else if (ctr_expire) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_BOOT;
      endcase
    end
  end

  // State, PC and registered outputs; reset overrides any handshake.
  always_ff @(posedge soc_clk) begin
    if (IF_reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      flush_addr_q <= '0;
      ir_q         <= NOP_INSTR;
      fpc_q        <= '0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      ir_q         <= ir_d;
      fpc_q        <= fpc_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
    end
  end

endmodule

// File: tb/tb_cu_if_fetch.sv
// Directed testbench for cu_if_fetch: per-cycle vector table plus a
// hand-written flush-timeout sequence.
module tb_cu_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] ir;
    logic [31:0] fpc;
    logic        flt;
    logic [1:0]  cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] cu_ir;
  logic [31:0] fpc;
  logic        rdy;
  logic        flt;
  logic [1:0]  cause;

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  cu_if_fetch_if imem_bus ();

  cu_if_fetch #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .soc_clk       (clk),
    .IF_reset      (rst),
    .IF_stall      (stall),
    .redirect_valid(rv),
    .redirect_pc   (rpc),
    .imem          (imem_bus),
    .Cu_IR         (cu_ir),
    .fetch_pc      (fpc),
    .Fetch_ready   (rdy),
    .fetch_fault   (flt),
    .fault_cause   (cause)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic addVec(input logic v_rst, input logic v_stall, input logic v_rv,
                        input logic [31:0] v_rpc, input logic v_ack, input logic v_err,
                        input logic [31:0] v_rdata, input logic v_chk, input logic v_req,
                        input logic [31:0] v_addr, input logic v_rdy, input logic [31:0] v_ir,
                        input logic [31:0] v_fpc, input logic v_flt, input logic [1:0] v_cause);
    vec_t v;
    v.rst = v_rst;   v.stall = v_stall; v.rv = v_rv;   v.rpc = v_rpc;
    v.ack = v_ack;   v.err = v_err;     v.rdata = v_rdata;
    v.chk = v_chk;   v.req = v_req;     v.addr = v_addr; v.rdy = v_rdy;
    v.ir = v_ir;     v.fpc = v_fpc;     v.flt = v_flt;   v.cause = v_cause;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    stall          = v.stall;
    rv             = v.rv;
    rpc            = v.rpc;
    imem_bus.ack   = v.ack;
    imem_bus.err   = v.err;
    imem_bus.rdata = v.rdata;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    if (v.chk) begin
      cmp("imem_req", idx, {31'd0, imem_bus.req}, {31'd0, v.req});
      if (v.req) cmp("imem_addr", idx, imem_bus.addr, v.addr);
      cmp("Fetch_ready", idx, {31'd0, rdy}, {31'd0, v.rdy});
      cmp("Cu_IR", idx, cu_ir, v.ir);
      cmp("fetch_pc", idx, fpc, v.fpc);
      cmp("fetch_fault", idx, {31'd0, flt}, {31'd0, v.flt});
      cmp("fault_cause", idx, {30'd0, cause}, {30'd0, v.cause});
    end
  endtask

  initial begin
    int flush_cycles;
    rst = 1'b1; stall = 1'b0; rv = 1'b0; rpc = '0;
    imem_bus.ack = 1'b0; imem_bus.err = 1'b0; imem_bus.rdata = '0;

    // rst stall rv rpc ack err rdata | chk req addr rdy ir fpc flt cause
    addVec('1,'0,'0,32'h0,'0,'0,32'h0,          '0,'0,32'h0,'0,NOP,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'0,NOP,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h0,'0,NOP,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'0,32'hA000_0000,  '1,'1,32'h0,'0,NOP,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'1,32'hA000_0000,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h4,'0,32'hA000_0000,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'0,32'hA000_0004,  '1,'1,32'h4,'0,32'hA000_0000,32'h0,'0,2'd0);
    addVec('0,'1,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'1,32'hA000_0004,32'h4,'0,2'd0);
    for (int i = 0; i < 4; i++)
      addVec('0,'1,'0,32'h0,'0,'0,32'h0,        '1,'0,32'h0,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'1,32'h100,'0,'0,32'h0,        '1,'1,32'h8,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h8,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h8,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'0,32'hDEAD_BEEF,  '1,'1,32'h8,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h100,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'0,32'hA000_0100,  '1,'1,32'h100,'0,32'hA000_0004,32'h4,'0,2'd0);
    addVec('0,'0,'1,32'h102,'0,'0,32'h0,        '1,'0,32'h0,'1,32'hA000_0100,32'h100,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'0,32'hA000_0100,32'h100,'1,2'd1);
    addVec('0,'0,'1,32'h200,'0,'0,32'h0,        '1,'0,32'h0,'0,32'hA000_0100,32'h100,'1,2'd1);
    addVec('0,'0,'0,32'h0,'1,'0,32'hA000_0200,  '1,'1,32'h200,'0,32'hA000_0100,32'h100,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'1,32'hA000_0200,32'h200,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'1,32'hBAD0_BAD0,  '1,'1,32'h204,'0,32'hA000_0200,32'h200,'0,2'd0);
    addVec('0,'0,'1,32'h300,'0,'0,32'h0,        '1,'0,32'h0,'0,32'hA000_0200,32'h200,'1,2'd2);
    for (int i = 0; i < 16; i++)
      addVec('0,'0,'0,32'h0,'0,'0,32'h0,        '1,'1,32'h300,'0,32'hA000_0200,32'h200,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'0,32'hA000_0200,32'h200,'1,2'd3);
    addVec('0,'0,'1,32'h400,'0,'0,32'h0,        '1,'0,32'h0,'0,32'hA000_0200,32'h200,'1,2'd3);
    addVec('1,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h400,'0,32'hA000_0200,32'h200,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'0,NOP,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'0,32'hA000_0000,  '1,'1,32'h0,'0,NOP,32'h0,'0,2'd0);
    addVec('0,'0,'1,32'hFFFF_FFFC,'0,'0,32'h0,  '1,'0,32'h0,'1,32'hA000_0000,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'1,'0,32'hC0DE_0000,  '1,'1,32'hFFFF_FFFC,'0,32'hA000_0000,32'h0,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'0,32'h0,'1,32'hC0DE_0000,32'hFFFF_FFFC,'0,2'd0);
    addVec('0,'0,'1,32'h500,'1,'0,32'h1111_1111,'1,'1,32'h0,'0,32'hC0DE_0000,32'hFFFF_FFFC,'0,2'd0);
    addVec('0,'0,'0,32'h0,'0,'0,32'h0,          '1,'1,32'h500,'0,32'hC0DE_0000,32'hFFFF_FFFC,'0,2'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Redirect into a flush that never gets its ack: old address must stay
    // on the bus for the full timeout, then fault with cause 11.
    @(negedge clk);
    cmp("pre_flush_addr", 1000, imem_bus.addr, 32'h500);
    rv = 1'b1; rpc = 32'h600;
    @(negedge clk);
    rv = 1'b0; rpc = '0;
    flush_cycles = 0;
    while (imem_bus.req && flush_cycles < 40) begin
      cmp("flush_addr", 1001, imem_bus.addr, 32'h500);
      cmp("flush_ready", 1001, {31'd0, rdy}, 32'd0);
      flush_cycles++;
      @(negedge clk);
    end
    cmp("flush_timeout_cycles", 1002, flush_cycles, 32'd16);
    cmp("flush_fault", 1002, {31'd0, flt}, 32'd1);
    cmp("flush_cause", 1002, {30'd0, cause}, 32'd3);
    cmp("flush_ir", 1002, cu_ir, 32'hC0DE_0000);
    rv = 1'b1; rpc = 32'h600;
    @(negedge clk);
    rv = 1'b0; rpc = '0;
    cmp("resume_req", 1003, {31'd0, imem_bus.req}, 32'd1);
    cmp("resume_addr", 1003, imem_bus.addr, 32'h600);
    cmp("resume_fault", 1003, {31'd0, flt}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cu_if_fetch.md
Name: cu_if_fetch

Overview:
Instruction-fetch stage of the CU pipeline, directly upstream of the decode stage. Owns the program counter and issues word requests to instruction memory over a req/ack handshake. Latches each returned word into Cu_IR and pulses Fetch_ready, which drives the decode stage's decode_start. Handles downstream stall, branch/jump redirect with in-flight discard, and fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, max cycles in S_FETCH without imem_ack before fault (range 2..255)

Ports:
soc_clk  in  1  system clock, all state on rising edge
IF_reset  in  1  synchronous active-high reset
IF_stall  in  1  downstream stall; holds delivered instruction, blocks next fetch
redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  32  new PC (branch/jump target)
imem_req  out  1  memory request; held until imem_ack
imem_addr  out  32  word address, equals current pc, stable while imem_req
imem_ack  in  1  one-cycle completion; imem_rdata/imem_err valid this cycle
imem_rdata  in  32  fetched instruction word
imem_err  in  1  bus error, qualified by imem_ack
Cu_IR  out  32  latched instruction to decode
fetch_pc  out  32  PC of the word in Cu_IR
Fetch_ready  out  1  one-cycle pulse: Cu_IR/fetch_pc newly valid
fetch_fault  out  1  sticky fault flag
fault_cause  out  2  00 none, 01 misaligned redirect, 10 bus error, 11 timeout

Behaviour:
- Reset (edge with IF_reset=1): state=S_BOOT, pc=RESET_PC, Cu_IR=32'h0000_0013 (NOP), fetch_pc=0, Fetch_ready=0, fetch_fault=0, fault_cause=00, timeout counter=0. imem_req is decoded from state, so it is low the cycle after reset. Reset has priority over everything, including mid-handshake. Memory shares IF_reset and abandons the outstanding request.
- States: S_BOOT, S_FETCH, S_HOLD, S_FLUSH, S_FAULT. imem_req=1 only in S_FETCH and S_FLUSH.
- S_BOOT: go to S_FETCH unconditionally (one idle cycle).
- S_FETCH, ack and no error: Cu_IR<=imem_rdata, fetch_pc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), Fetch_ready<=1, go to S_HOLD.
- S_FETCH, ack with error: fault_cause=10, go to S_FAULT. Cu_IR is unchanged and there is no Fetch_ready.
- S_FETCH, no ack: counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack: fault_cause=11, go to S_FAULT, drop req.
- Latency: ack in cycle N -> Cu_IR valid and Fetch_ready=1 in N+1. Next req no earlier than N+2.
- S_HOLD: Fetch_ready is high only on entry (one pulse, never re-pulsed while stalled). If IF_stall=0, go to S_FETCH. If IF_stall=1, stay, with Cu_IR/fetch_pc frozen.
- Redirect (priority above stall, ack, timeout; below reset), any state:
  - redirect_pc[1:0]!=0: fault_cause=01, go to S_FAULT.
  - S_FETCH without ack the same cycle: pc<=redirect_pc, go to S_FLUSH. Req stays asserted at the old address until ack, then the data is discarded.
  - S_FETCH with ack the same cycle: discard data, no Fetch_ready, pc<=redirect_pc, go to S_FETCH.
  - S_FLUSH with ack the same cycle: pc<=redirect_pc, go to S_FETCH.
  - S_FLUSH without ack: pc<=redirect_pc, stay.
  - S_HOLD/S_BOOT/S_FAULT: pc<=redirect_pc, go to S_FETCH. fetch_fault/fault_cause clear on an aligned redirect.
- S_FLUSH: on ack (error ignored) go to S_FETCH at the new pc. No Fetch_ready. The timeout applies and faults with 11.
- S_FAULT: req low, holds until reset or an aligned redirect.
- The timeout counter clears on every state transition.

Decomposition:
- cu_pkg: fetch state enum, NOP_INSTR constant, fault_cause encodings, XLEN=32.
- Sub-module fetch_timeout_ctr (clear/enable/expire, width from TIMEOUT_CYCLES) instantiated once.
- The FSM, PC and IR stay in cu_if_fetch.

Test Plan:
- Reset, memory acks every request 1 cycle after req, IF_stall=0 -> imem_addr 0,4,8. Fetch_ready pulses every 3 cycles with fetch_pc 0,4,8, Cu_IR = memory words. Cu_IR=0x13 before the first pulse.
- Ack at addr 4, IF_stall held 5 cycles -> exactly one Fetch_ready pulse. Cu_IR/fetch_pc stay at 4 and no req while stalled. Req for 8 appears 1 cycle after the stall drops.
- Ack delayed 3 cycles at addr 8, redirect_valid with redirect_pc=0x100 in the 1st wait cycle -> req remains at 8 until ack, that data is never delivered, next req addr 0x100, next Fetch_ready fetch_pc=0x100.
- redirect_pc=0x102 -> fetch_fault=1, fault_cause=01, req low. Then redirect_pc=0x200 -> fault clears, fetch resumes at 0x200.
- Ack with imem_err=1 -> fault_cause=10, no Fetch_ready. Separately, no ack for 16 cycles -> fault_cause=11, req drops.
- IF_reset during an outstanding req -> next cycle req=0, all outputs at reset values, fetch restarts at RESET_PC after S_BOOT.
